// File: rtl/mrna_iso_pkg.sv
// mrna_iso_pkg
// Shared definitions for the mRNA isolation chip sequencer:
//   - sequencer state enum and phase ordering helpers
//   - pump drive patterns and valve line levels
//   - lane count of the chip netlist
package mrna_iso_pkg;

    localparam int NLANES  = 4;
    localparam int NPHASES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOAD,
        ST_LYSE,
        ST_BIND,
        ST_WASH,
        ST_COLLECT,
        ST_FLUSH
    } seq_state_t;

    // Three-phase peristaltic pattern; one line is vented per step.
    localparam logic [2:0] PUMP_A   = 3'b110;
    localparam logic [2:0] PUMP_B   = 3'b101;
    localparam logic [2:0] PUMP_C   = 3'b011;
    localparam logic [2:0] PUMP_OFF = 3'b111;

    // A pressurised control line closes its valve.
    localparam logic VALVE_CLOSED = 1'b1;
    localparam logic VALVE_OPEN   = 1'b0;

    function automatic logic is_phase(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_GRANT);
    endfunction

    function automatic logic pump_runs(input seq_state_t s);
        return (s == ST_LOAD) || (s == ST_LYSE) || (s == ST_BIND) || (s == ST_WASH);
    endfunction

    function automatic seq_state_t phase_state(input int k);
        case (k)
            0:       return ST_LOAD;
            1:       return ST_LYSE;
            2:       return ST_BIND;
            3:       return ST_WASH;
            4:       return ST_COLLECT;
            default: return ST_FLUSH;
        endcase
    endfunction

    // Index of the first phase that may follow the given state.
    function automatic int phase_pos(input seq_state_t s);
        case (s)
            ST_GRANT:   return 0;
            ST_LOAD:    return 1;
            ST_LYSE:    return 2;
            ST_BIND:    return 3;
            ST_WASH:    return 4;
            ST_COLLECT: return 5;
            default:    return NPHASES;
        endcase
    endfunction

    // First later phase with a non-zero duration (bit k of nz is phase k),
    // or IDLE when the protocol has nothing left to run.
    function automatic seq_state_t next_phase(input seq_state_t cur, input logic [5:0] nz);
        seq_state_t nxt;
        logic       found;
        nxt   = ST_IDLE;
        found = 1'b0;
        for (int k = 0; k < NPHASES; k++) begin
            if (!found && (k >= phase_pos(cur)) && nz[k]) begin
                nxt   = phase_state(k);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mrna_rr_arbiter.sv
// mrna_rr_arbiter
// Four-request round-robin arbiter for the shared fluid lines.
//   clk, rst   : clock, synchronous active-high reset
//   req        : pending lane requests
//   grant_en   : a grant is taken this cycle; advances the pointer
//   gnt_valid  : some request is selectable
//   gnt_lane   : encoded selected lane
//   gnt_onehot : one-hot selected lane
module mrna_rr_arbiter
    import mrna_iso_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NLANES-1:0] req,
    input  logic              grant_en,
    output logic              gnt_valid,
    output logic [1:0]        gnt_lane,
    output logic [NLANES-1:0] gnt_onehot
);

    logic [1:0] ptr;

    // Scan from the pointer upward; the 2-bit sum wraps modulo 4.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_lane  = 2'd0;
        for (int i = 0; i < NLANES; i++) begin
            if (!gnt_valid && req[ptr + 2'(i)]) begin
                gnt_valid = 1'b1;
                gnt_lane  = ptr + 2'(i);
            end
        end
        gnt_onehot = gnt_valid ? (NLANES'(1) << gnt_lane) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (grant_en && gnt_valid) begin
            ptr <= gnt_lane + 2'd1;
        end
    end

endmodule

// File: rtl/mrna_iso_sequencer.sv
// mrna_iso_sequencer
// Pneumatic control sequencer for the four-lane mRNA isolation chip.
// Arbitrates lane run requests and walks the granted lane through
// LOAD, LYSE, BIND, WASH, COLLECT (and optionally FLUSH).
// Optional feature macro: MRNAISO_SEQ_FLUSH_EN adds the FLUSH phase.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start[4], abort          : run request pulses, run termination
//   pump_div, t_*            : pump step divider and phase durations
//   cells_in/out, collect_ctl: per-lane valve lines (1 = closed)
//   lysis/bead/push/sep/sieve/waste_ctl : shared valve lines
//   pump_ctl[3]              : peristaltic pump lines
//   busy, active_lane, done  : run status and completion pulse
module mrna_iso_sequencer #(
    parameter int NLANES = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NLANES-1:0] start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  pump_div,
    input  logic [CNT_W-1:0]  t_load,
    input  logic [CNT_W-1:0]  t_lyse,
    input  logic [CNT_W-1:0]  t_bind,
    input  logic [CNT_W-1:0]  t_wash,
    input  logic [CNT_W-1:0]  t_collect,
    input  logic [CNT_W-1:0]  t_flush,
    output logic [NLANES-1:0] cells_in_ctl,
    output logic [NLANES-1:0] cells_out_ctl,
    output logic [NLANES-1:0] collect_ctl,
    output logic              lysis_in_ctl,
    output logic              lysis_waste_ctl,
    output logic              beads_in_ctl,
    output logic              bead_waste_ctl,
    output logic              push_ctl,
    output logic              sep_ctl,
    output logic              sieve_ctl,
    output logic              waste_ctl,
    output logic [2:0]        pump_ctl,
    output logic              busy,
    output logic [1:0]        active_lane,
    output logic [NLANES-1:0] done
);
    import mrna_iso_pkg::*;

`ifdef MRNAISO_SEQ_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    seq_state_t        state, state_nxt;
    logic [NLANES-1:0] pending;
    logic [1:0]        lane_q, lane_nxt;
    logic [CNT_W-1:0]  div_q, d_load, d_lyse, d_bind, d_wash, d_collect, d_flush;
    logic [CNT_W-1:0]  div_cnt, step_cnt, cur_dur;
    logic [5:0]        in_nz, lat_nz;
    logic              tick, phase_end, grant_en, grant_take, run_end, entering;
    logic              gnt_valid;
    logic [1:0]        gnt_lane;
    logic [NLANES-1:0] gnt_onehot;

    logic [NLANES-1:0] cells_in_nxt, cells_out_nxt, collect_nxt;
    logic lysis_in_nxt, lysis_waste_nxt, beads_in_nxt, bead_waste_nxt;
    logic push_nxt, sep_nxt, sieve_nxt, waste_nxt;

    assign grant_en = (state == ST_GRANT) && !abort;

    mrna_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (pending),
        .grant_en   (grant_en),
        .gnt_valid  (gnt_valid),
        .gnt_lane   (gnt_lane),
        .gnt_onehot (gnt_onehot)
    );

    // Next-state logic. At GRANT the skip decision uses the live t_* inputs,
    // because they are being latched on this very edge.
    always_comb begin
        in_nz  = {FLUSH_EN & (t_flush != '0), t_collect != '0, t_wash != '0,
                  t_bind != '0, t_lyse != '0, t_load != '0};
        lat_nz = {FLUSH_EN & (d_flush != '0), d_collect != '0, d_wash != '0,
                  d_bind != '0, d_lyse != '0, d_load != '0};
        case (state)
            ST_LOAD:    cur_dur = d_load;
            ST_LYSE:    cur_dur = d_lyse;
            ST_BIND:    cur_dur = d_bind;
            ST_WASH:    cur_dur = d_wash;
            ST_COLLECT: cur_dur = d_collect;
            ST_FLUSH:   cur_dur = d_flush;
            default:    cur_dur = '0;
        endcase
        tick       = (div_cnt == div_q);
        phase_end  = tick && (step_cnt == cur_dur - CNT_W'(1));
        grant_take = grant_en && gnt_valid;
        state_nxt  = state;
        lane_nxt   = lane_q;
        run_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((pending | start) != '0) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                if (grant_take) begin
                    state_nxt = next_phase(ST_GRANT, in_nz);
                    lane_nxt  = gnt_lane;
                    run_end   = (state_nxt == ST_IDLE);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (phase_end) begin
                    state_nxt = next_phase(state, lat_nz);
                    run_end   = (state_nxt == ST_IDLE);
                end
            end
        endcase
        entering = is_phase(state_nxt) && (state_nxt != state);
    end

    // Valve levels for the coming cycle; everything not listed stays closed.
    always_comb begin
        cells_in_nxt    = '1;
        cells_out_nxt   = '1;
        collect_nxt     = '1;
        lysis_in_nxt    = VALVE_CLOSED;
        lysis_waste_nxt = VALVE_CLOSED;
        beads_in_nxt    = VALVE_CLOSED;
        bead_waste_nxt  = VALVE_CLOSED;
        push_nxt        = VALVE_CLOSED;
        sep_nxt         = VALVE_CLOSED;
        sieve_nxt       = VALVE_CLOSED;
        waste_nxt       = VALVE_CLOSED;
        case (state_nxt)
            ST_LOAD: begin
                cells_in_nxt[lane_nxt]  = VALVE_OPEN;
                cells_out_nxt[lane_nxt] = VALVE_OPEN;
            end
            ST_LYSE: begin
                lysis_in_nxt    = VALVE_OPEN;
                lysis_waste_nxt = VALVE_OPEN;
            end
            ST_BIND: begin
                beads_in_nxt   = VALVE_OPEN;
                bead_waste_nxt = VALVE_OPEN;
                sieve_nxt      = VALVE_OPEN;
            end
            ST_WASH: begin
                sep_nxt   = VALVE_OPEN;
                waste_nxt = VALVE_OPEN;
            end
            ST_COLLECT: begin
                collect_nxt[lane_nxt] = VALVE_OPEN;
                push_nxt              = VALVE_OPEN;
            end
            ST_FLUSH: begin
                waste_nxt = VALVE_OPEN;
                push_nxt  = VALVE_OPEN;
            end
            default: ;
        endcase
    end

    // State, request bookkeeping, counters and registered outputs.
    // A start landing in the grant cycle for the granted lane survives the
    // clear so that it queues a re-run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            pending         <= '0;
            lane_q          <= 2'd0;
            div_q           <= '0;
            d_load          <= '0;
            d_lyse          <= '0;
            d_bind          <= '0;
            d_wash          <= '0;
            d_collect       <= '0;
            d_flush         <= '0;
            div_cnt         <= '0;
            step_cnt        <= '0;
            cells_in_ctl    <= '1;
            cells_out_ctl   <= '1;
            collect_ctl     <= '1;
            lysis_in_ctl    <= VALVE_CLOSED;
            lysis_waste_ctl <= VALVE_CLOSED;
            beads_in_ctl    <= VALVE_CLOSED;
            bead_waste_ctl  <= VALVE_CLOSED;
            push_ctl        <= VALVE_CLOSED;
            sep_ctl         <= VALVE_CLOSED;
            sieve_ctl       <= VALVE_CLOSED;
            waste_ctl       <= VALVE_CLOSED;
            pump_ctl        <= PUMP_OFF;
            busy            <= 1'b0;
            active_lane     <= 2'd0;
            done            <= '0;
        end else begin
            pending <= (pending & ~(grant_take ? gnt_onehot : '0)) | start;
            state   <= state_nxt;
            lane_q  <= lane_nxt;
            if (grant_take) begin
                div_q     <= pump_div;
                d_load    <= t_load;
                d_lyse    <= t_lyse;
                d_bind    <= t_bind;
                d_wash    <= t_wash;
                d_collect <= t_collect;
                d_flush   <= t_flush;
            end
            if (entering) begin
                div_cnt  <= '0;
                step_cnt <= '0;
            end else if (is_phase(state)) begin
                if (tick) begin
                    div_cnt  <= '0;
                    step_cnt <= step_cnt + CNT_W'(1);
                end else begin
                    div_cnt <= div_cnt + CNT_W'(1);
                end
            end
            if (!pump_runs(state_nxt)) begin
                pump_ctl <= PUMP_OFF;
            end else if (entering) begin
                pump_ctl <= PUMP_A;
            end else if (tick) begin
                pump_ctl <= {pump_ctl[1:0], pump_ctl[2]};
            end
            cells_in_ctl    <= cells_in_nxt;
            cells_out_ctl   <= cells_out_nxt;
            collect_ctl     <= collect_nxt;
            lysis_in_ctl    <= lysis_in_nxt;
            lysis_waste_ctl <= lysis_waste_nxt;
            beads_in_ctl    <= beads_in_nxt;
            bead_waste_ctl  <= bead_waste_nxt;
            push_ctl        <= push_nxt;
            sep_ctl         <= sep_nxt;
            sieve_ctl       <= sieve_nxt;
            waste_ctl       <= waste_nxt;
            busy            <= is_phase(state_nxt);
            active_lane     <= is_phase(state_nxt) ? lane_nxt : 2'd0;
            done            <= run_end ? (NLANES'(1) << lane_nxt) : '0;
        end
    end

endmodule

// File: tb/tb_mrna_iso_sequencer.sv
// tb_mrna_iso_sequencer
// Self-checking bench for mrna_iso_sequencer. Expected output words come from
// a cycle-trace model built from phase durations, the valve map and a
// round-robin pick computed with plain arithmetic.
// Honours MRNAISO_SEQ_FLUSH_EN when compiled with the same define as the RTL.
module tb_mrna_iso_sequencer;

    typedef logic [29:0] word_t;

`ifdef MRNAISO_SEQ_FLUSH_EN
    localparam int NPH = 6;
`else
    localparam int NPH = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic [3:0]  start;
    logic [15:0] pump_div, t_load, t_lyse, t_bind, t_wash, t_collect, t_flush;
    logic [3:0]  cells_in_ctl, cells_out_ctl, collect_ctl;
    logic        lysis_in_ctl, lysis_waste_ctl, beads_in_ctl, bead_waste_ctl;
    logic        push_ctl, sep_ctl, sieve_ctl, waste_ctl;
    logic [2:0]  pump_ctl;
    logic        busy;
    logic [1:0]  active_lane;
    logic [3:0]  done;

    always #5 clk = ~clk;

    mrna_iso_sequencer #(.NLANES(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .pump_div        (pump_div),
        .t_load          (t_load),
        .t_lyse          (t_lyse),
        .t_bind          (t_bind),
        .t_wash          (t_wash),
        .t_collect       (t_collect),
        .t_flush         (t_flush),
        .cells_in_ctl    (cells_in_ctl),
        .cells_out_ctl   (cells_out_ctl),
        .collect_ctl     (collect_ctl),
        .lysis_in_ctl    (lysis_in_ctl),
        .lysis_waste_ctl (lysis_waste_ctl),
        .beads_in_ctl    (beads_in_ctl),
        .bead_waste_ctl  (bead_waste_ctl),
        .push_ctl        (push_ctl),
        .sep_ctl         (sep_ctl),
        .sieve_ctl       (sieve_ctl),
        .waste_ctl       (waste_ctl),
        .pump_ctl        (pump_ctl),
        .busy            (busy),
        .active_lane     (active_lane),
        .done            (done)
    );

    word_t obs;
    assign obs = {cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl,
                  beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl,
                  pump_ctl, busy, active_lane, done};

    localparam word_t IDLE_W = {12'hFFF, 8'hFF, 3'b111, 1'b0, 2'b00, 4'h0};

    int         n_checks = 0;
    int         n_fail   = 0;
    int         dur [6];
    int         div_m;
    word_t      exp_q [$];
    logic [2:0] pats [3] = '{3'b110, 3'b101, 3'b011};

    // Output word for phase ph (0..5, -1 = idle) of lane, with a pump level.
    function automatic word_t mk_word(input int ph, input int lane, input logic [2:0] pump,
                                      input logic dn);
        logic [3:0] ci, co, cl, dmask;
        logic li, lw, bi, bw, pu, se, si, wa, bz;
        logic [1:0] al;
        ci = 4'hF; co = 4'hF; cl = 4'hF;
        {li, lw, bi, bw, pu, se, si, wa} = 8'hFF;
        case (ph)
            0: begin ci[lane] = 1'b0; co[lane] = 1'b0; end
            1: begin li = 1'b0; lw = 1'b0; end
            2: begin bi = 1'b0; bw = 1'b0; si = 1'b0; end
            3: begin se = 1'b0; wa = 1'b0; end
            4: begin cl[lane] = 1'b0; pu = 1'b0; end
            5: begin wa = 1'b0; pu = 1'b0; end
            default: ;
        endcase
        bz    = (ph >= 0);
        al    = bz ? 2'(lane) : 2'd0;
        dmask = dn ? 4'(1 << lane) : 4'h0;
        return {ci, co, cl, li, lw, bi, bw, pu, se, si, wa, pump, bz, al, dmask};
    endfunction

    // Cycle-by-cycle expectation of one run, starting at its first phase
    // cycle and ending with the done cycle.
    task automatic build_trace(input int lane);
        exp_q.delete();
        for (int ph = 0; ph < NPH; ph++) begin
            for (int c = 0; c < dur[ph] * (div_m + 1); c++) begin
                exp_q.push_back(mk_word(ph, lane,
                    (ph < 4) ? pats[(c / (div_m + 1)) % 3] : 3'b111, 1'b0));
            end
        end
        exp_q.push_back(mk_word(-1, lane, 3'b111, 1'b1));
    endtask

    function automatic int rr_pick(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic drive_cfg();
        pump_div  = 16'(div_m);
        t_load    = 16'(dur[0]);
        t_lyse    = 16'(dur[1]);
        t_bind    = 16'(dur[2]);
        t_wash    = 16'(dur[3]);
        t_collect = 16'(dur[4]);
        t_flush   = 16'(dur[5]);
    endtask

    task automatic set_all(input int t, input int dv);
        for (int k = 0; k < 6; k++) dur[k] = t;
        div_m = dv;
        drive_cfg();
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 4'h0; abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL reset_idle: got %h expected %h", obs, IDLE_W);
        end
        set_all(1, 0);
        start = 4'b0011;
        @(negedge clk);
        start = 4'h0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_run_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL reset_midrun: got %h expected %h", obs, IDLE_W);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL reset_pending_clear: got %h expected %h", obs, IDLE_W);
        end
    endtask

    task automatic test_single_lane();
        int done_at;
        int want_done;
        apply_reset();
        set_all(2, 1);
        build_trace(2);
        want_done = (NPH == 6) ? 24 : 20;
        start = 4'b0100;
        @(negedge clk);
        start = 4'h0;
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL single_grant: got %h expected %h", obs, IDLE_W);
        end
        @(negedge clk);
        done_at = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++; $display("[TB] FAIL single_trace[%0d]: got %h expected %h", i, obs, exp_q[i]);
            end
            if (i == 0) begin
                n_checks++;
                if (cells_in_ctl !== 4'b1011) begin
                    n_fail++; $display("[TB] FAIL single_cells_in: got %b expected 1011", cells_in_ctl);
                end
            end
            if (done[2] === 1'b1 && done_at < 0) done_at = i;
            @(negedge clk);
        end
        n_checks++;
        if (done_at != want_done) begin
            n_fail++; $display("[TB] FAIL single_done_time: got %0d expected %0d", done_at, want_done);
        end
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL single_after: got %h expected %h", obs, IDLE_W);
        end
    endtask

    task automatic test_arbitration();
        int order [5] = '{0, 1, 3, 0, 2};
        apply_reset();
        set_all(1, 0);
        start = 4'b1011;
        @(negedge clk);
        start = 4'h0;
        for (int r = 0; r < 5; r++) begin
            n_checks++;
            if (obs !== IDLE_W) begin
                n_fail++; $display("[TB] FAIL arb_grant_gap[%0d]: got %h expected %h", r, obs, IDLE_W);
            end
            @(negedge clk);
            build_trace(order[r]);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs !== exp_q[i]) begin
                    n_fail++; $display("[TB] FAIL arb_trace[%0d][%0d]: got %h expected %h", r, i, obs, exp_q[i]);
                end
                start = (r == 2 && i == 0) ? 4'b0101 : 4'h0;
                @(negedge clk);
            end
            start = 4'h0;
        end
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL arb_after: got %h expected %h", obs, IDLE_W);
        end
    endtask

    task automatic test_skip();
        int lysis_open;
        int sep_open;
        apply_reset();
        dur = '{2, 0, 3, 0, 1, 0};
        div_m = 0;
        drive_cfg();
        build_trace(1);
        start = 4'b0010;
        @(negedge clk);
        start = 4'h0;
        @(negedge clk);
        lysis_open = 0;
        sep_open   = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++; $display("[TB] FAIL skip_trace[%0d]: got %h expected %h", i, obs, exp_q[i]);
            end
            if (lysis_in_ctl !== 1'b1) lysis_open++;
            if (sep_ctl !== 1'b1) sep_open++;
            @(negedge clk);
        end
        n_checks++;
        if (lysis_open != 0 || sep_open != 0) begin
            n_fail++; $display("[TB] FAIL skip_closed: got lysis %0d sep %0d open cycles expected 0", lysis_open, sep_open);
        end
        set_all(0, 2);
        build_trace(3);
        start = 4'b1000;
        @(negedge clk);
        start = 4'h0;
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL zero_grant: got %h expected %h", obs, IDLE_W);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== exp_q[0]) begin
            n_fail++; $display("[TB] FAIL zero_done: got %h expected %h", obs, exp_q[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        apply_reset();
        set_all(2, 1);
        build_trace(1);
        start = 4'b0010;
        abort = 1'b1;
        @(negedge clk);
        start = 4'h0;
        abort = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++; $display("[TB] FAIL abort_pre[%0d]: got %h expected %h", i, obs, exp_q[i]);
            end
            start = (i == 3) ? 4'b1000 : ((i == 13) ? 4'b0001 : 4'h0);
            abort = (i == 13);
            @(negedge clk);
        end
        start = 4'h0;
        abort = 1'b0;
        n_checks++;
        if (obs !== IDLE_W) begin
            n_fail++; $display("[TB] FAIL abort_reset: got %h expected %h", obs, IDLE_W);
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== IDLE_W) begin
                n_fail++; $display("[TB] FAIL abort_grant[%0d]: got %h expected %h", r, obs, IDLE_W);
            end
            @(negedge clk);
            build_trace((r == 0) ? 3 : 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs !== exp_q[i]) begin
                    n_fail++; $display("[TB] FAIL abort_requeue[%0d][%0d]: got %h expected %h", r, i, obs, exp_q[i]);
                end
                if (i < exp_q.size() - 1) @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int done_at;
        int both_open;
        int want_done;
        apply_reset();
        dur = '{1, 1, 1, 1, 1, 3};
        div_m = 0;
        drive_cfg();
        build_trace(0);
        want_done = (NPH == 6) ? 8 : 5;
        start = 4'b0001;
        @(negedge clk);
        start = 4'h0;
        @(negedge clk);
        done_at   = -1;
        both_open = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++; $display("[TB] FAIL flush_trace[%0d]: got %h expected %h", i, obs, exp_q[i]);
            end
            if (waste_ctl === 1'b0 && push_ctl === 1'b0) both_open++;
            if (done[0] === 1'b1 && done_at < 0) done_at = i;
            @(negedge clk);
        end
        n_checks++;
        if (done_at != want_done) begin
            n_fail++; $display("[TB] FAIL flush_done_time: got %0d expected %0d", done_at, want_done);
        end
        n_checks++;
        if (both_open != ((NPH == 6) ? 3 : 0)) begin
            n_fail++; $display("[TB] FAIL flush_cycles: got %0d expected %0d", both_open, (NPH == 6) ? 3 : 0);
        end
    endtask

    task automatic test_random();
        logic [3:0] mpend;
        logic [3:0] mask;
        int         mptr;
        int         lane;
        apply_reset();
        mptr  = 0;
        mpend = 4'h0;
        for (int k = 0; k < 6; k++) dur[k] = $urandom_range(0, 3);
        div_m = $urandom_range(0, 2);
        drive_cfg();
        for (int b = 0; b < 6; b++) begin
            mask  = 4'($urandom_range(1, 15));
            mpend = mpend | mask;
            start = mask;
            @(negedge clk);
            start = 4'h0;
            while (mpend != 4'h0) begin
                lane = rr_pick(mpend, mptr);
                mpend[lane] = 1'b0;
                mptr = (lane + 1) % 4;
                n_checks++;
                if (obs !== IDLE_W) begin
                    n_fail++; $display("[TB] FAIL rand_grant[%0d]: got %h expected %h", b, obs, IDLE_W);
                end
                build_trace(lane);
                @(negedge clk);
                for (int k = 0; k < 6; k++) dur[k] = $urandom_range(0, 3);
                div_m = $urandom_range(0, 2);
                drive_cfg();
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (obs !== exp_q[i]) begin
                        n_fail++; $display("[TB] FAIL rand_trace[%0d] lane %0d[%0d]: got %h expected %h", b, lane, i, obs, exp_q[i]);
                    end
                    @(negedge clk);
                end
            end
            n_checks++;
            if (obs !== IDLE_W) begin
                n_fail++; $display("[TB] FAIL rand_idle[%0d]: got %h expected %h", b, obs, IDLE_W);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 4'h0; abort = 1'b0;
        set_all(0, 0);
        @(negedge clk);
        test_reset();
        test_single_lane();
        test_arbitration();
        test_skip();
        test_abort();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
